// File: rtl/ext_pwr_ctrl_pkg.sv
// Shared types for the external power-domain sequencer: state encoding,
// the bundle of domain control bits and the per-state control table.
package ext_pwr_ctrl_pkg;

  typedef enum logic [3:0] {
    OFF        = 4'd0,
    ON_SWITCH  = 4'd1,
    ON_RST     = 4'd2,
    ON_ISO     = 4'd3,
    ON_CLK     = 4'd4,
    ON         = 4'd5,
    OFF_CLK    = 4'd6,
    OFF_ISO    = 4'd7,
    OFF_RST    = 4'd8,
    OFF_SWITCH = 4'd9
  } pwr_state_e;

  typedef struct packed {
    logic switch_n;
    logic iso_n;
    logic rst_n;
    logic clkgate_en_n;
    logic ram_retentive_n;
  } pwr_ctrl_out_t;

  localparam pwr_ctrl_out_t PWR_CTRL_OUT_RST = '{
    switch_n:        1'b1,
    iso_n:           1'b0,
    rst_n:           1'b0,
    clkgate_en_n:    1'b0,
    ram_retentive_n: 1'b1
  };

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_step_state(input logic [3:0] state);
    logic res;
    case (state)
      ON_RST, ON_ISO, ON_CLK, OFF_CLK, OFF_ISO, OFF_RST: res = 1'b1;
      default:                                          res = 1'b0;
    endcase
    return res;
  endfunction

  // Control bits owned by each state; retention is only honoured while ON.
  function automatic pwr_ctrl_out_t ctrl_for_state(input logic [3:0] state, input logic ret_req);
    pwr_ctrl_out_t c;
    c = PWR_CTRL_OUT_RST;
    case (state)
      ON_SWITCH: begin
        c.switch_n = 1'b0;
      end
      ON_RST, OFF_ISO: begin
        c.switch_n = 1'b0;
        c.rst_n    = 1'b1;
      end
      ON_ISO, OFF_CLK: begin
        c.switch_n = 1'b0;
        c.rst_n    = 1'b1;
        c.iso_n    = 1'b1;
      end
      ON_CLK: begin
        c.switch_n     = 1'b0;
        c.rst_n        = 1'b1;
        c.iso_n        = 1'b1;
        c.clkgate_en_n = 1'b1;
      end
      ON: begin
        c.switch_n        = 1'b0;
        c.rst_n           = 1'b1;
        c.iso_n           = 1'b1;
        c.clkgate_en_n    = 1'b1;
        c.ram_retentive_n = ~ret_req;
      end
      OFF_RST: begin
        c.switch_n = 1'b0;
      end
      default: begin
        c = PWR_CTRL_OUT_RST;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ext_power_domain_ctrl_ack_sync.sv
// Two-flop synchronizer for the asynchronous power-switch acknowledge.
module pwr_ack_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_r;

  // Shift the raw ack through two flops before it reaches any logic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_r <= {2{RST_VAL}};
    end else begin
      sync_r <= {sync_r[0], d_i};
    end
  end

  assign q_o = sync_r[1];

endmodule

// File: rtl/ext_power_domain_ctrl.sv
// Power sequencer for one external domain: switch, reset, isolation, clock gate
// and RAM retention are driven in a fixed order, with a sticky ack-timeout flag.
module ext_power_domain_ctrl
  import ext_pwr_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned CNT_W       = $clog2(max_u(STEP_CYCLES, ACK_TIMEOUT)) + 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pwr_on_req_i,
  input  logic       ret_req_i,
  input  logic       switch_ack_ni,
  input  logic       err_clr_i,
  output logic       switch_n_o,
  output logic       iso_n_o,
  output logic       rst_n_o,
  output logic       clkgate_en_n_o,
  output logic       ram_retentive_n_o,
  output logic       pwr_on_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [3:0] state_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ACK_SAT   = CNT_W'(ACK_TIMEOUT);

  logic [3:0]       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  pwr_ctrl_out_t    ctrl_r, ctrl_nxt_s;
  logic             pwr_on_r, busy_r, timeout_r;
  logic             ack_n_s, ack_wait_s, step_done_s, timeout_set_s;

  pwr_ack_sync #(.RST_VAL(1'b1)) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (switch_ack_ni),
    .q_o    (ack_n_s)
  );

  assign step_done_s   = (cnt_r == CNT_ZERO);
  assign ack_wait_s    = ((state_r == ON_SWITCH) && ack_n_s) ||
                         ((state_r == OFF_SWITCH) && !ack_n_s);
  // Fires once per wait: the counter only passes ACK_LAST on its way to saturation.
  assign timeout_set_s = ack_wait_s && (cnt_r == ACK_LAST);
  assign ctrl_nxt_s    = ctrl_for_state(state_nxt_s, ret_req_i);

  // Sequencing FSM; requests are only looked at in OFF and ON.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      OFF:        if (pwr_on_req_i) state_nxt_s = ON_SWITCH;  else state_nxt_s = OFF;
      ON_SWITCH:  if (!ack_n_s)     state_nxt_s = ON_RST;     else state_nxt_s = ON_SWITCH;
      ON_RST:     if (step_done_s)  state_nxt_s = ON_ISO;     else state_nxt_s = ON_RST;
      ON_ISO:     if (step_done_s)  state_nxt_s = ON_CLK;     else state_nxt_s = ON_ISO;
      ON_CLK:     if (step_done_s)  state_nxt_s = ON;         else state_nxt_s = ON_CLK;
      ON:         if (!pwr_on_req_i) state_nxt_s = OFF_CLK;   else state_nxt_s = ON;
      OFF_CLK:    if (step_done_s)  state_nxt_s = OFF_ISO;    else state_nxt_s = OFF_CLK;
      OFF_ISO:    if (step_done_s)  state_nxt_s = OFF_RST;    else state_nxt_s = OFF_ISO;
      OFF_RST:    if (step_done_s)  state_nxt_s = OFF_SWITCH; else state_nxt_s = OFF_RST;
      OFF_SWITCH: if (ack_n_s)      state_nxt_s = OFF;        else state_nxt_s = OFF_SWITCH;
      default:                      state_nxt_s = OFF;
    endcase
  end

  // Shared counter: dwell countdown in step states, saturating up-count in ack waits.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (state_nxt_s != state_r) begin
      if (is_step_state(state_nxt_s)) begin
        cnt_nxt_s = STEP_LOAD;
      end else begin
        cnt_nxt_s = CNT_ZERO;
      end
    end else if ((state_r == ON_SWITCH) || (state_r == OFF_SWITCH)) begin
      if (cnt_r != ACK_SAT) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (cnt_r != CNT_ZERO) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State, counter and all status/control outputs register the next-state view.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= OFF;
      cnt_r    <= CNT_ZERO;
      ctrl_r   <= PWR_CTRL_OUT_RST;
      pwr_on_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      ctrl_r   <= ctrl_nxt_s;
      pwr_on_r <= (state_nxt_s == ON);
      busy_r   <= (state_nxt_s != OFF) && (state_nxt_s != ON);
    end
  end

  // Sticky timeout flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_r <= 1'b0;
    end else if (timeout_set_s) begin
      timeout_r <= 1'b1;
    end else if (err_clr_i) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign switch_n_o        = ctrl_r.switch_n;
  assign iso_n_o           = ctrl_r.iso_n;
  assign rst_n_o           = ctrl_r.rst_n;
  assign clkgate_en_n_o    = ctrl_r.clkgate_en_n;
  assign ram_retentive_n_o = ctrl_r.ram_retentive_n;
  assign pwr_on_o          = pwr_on_r;
  assign busy_o            = busy_r;
  assign timeout_o         = timeout_r;
  assign state_o           = state_r;

endmodule

// File: tb/tb_ext_power_domain_ctrl.sv
// Scoreboard bench: every output change is matched against a queued, hand-computed
// expectation including the cycle gap since the previous change.
module tb_ext_power_domain_ctrl;
  import ext_pwr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pwr_on_req = 1'b0;
  logic ret_req = 1'b0;
  logic err_clr = 1'b0;
  logic ack_stuck = 1'b0;
  logic switch_ack_n;
  logic switch_n, iso_n, dom_rst_n, clkgate_en_n, ram_ret_n, pwr_on, busy, timeout;
  logic [3:0] state;
  logic [14:0] ack_dly = 15'h7fff;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [11:0] vec;
    int          gap;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Switch-cell model: ack follows switch_n 15 negedges later.
  always @(negedge clk) ack_dly <= {ack_dly[13:0], switch_n};
  assign switch_ack_n = ack_stuck ? 1'b1 : ack_dly[14];

  ext_power_domain_ctrl #(.STEP_CYCLES(4), .ACK_TIMEOUT(64)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .pwr_on_req_i      (pwr_on_req),
    .ret_req_i         (ret_req),
    .switch_ack_ni     (switch_ack_n),
    .err_clr_i         (err_clr),
    .switch_n_o        (switch_n),
    .iso_n_o           (iso_n),
    .rst_n_o           (dom_rst_n),
    .clkgate_en_n_o    (clkgate_en_n),
    .ram_retentive_n_o (ram_ret_n),
    .pwr_on_o          (pwr_on),
    .busy_o            (busy),
    .timeout_o         (timeout),
    .state_o           (state)
  );

  function automatic logic [11:0] outs();
    return {state, switch_n, iso_n, dom_rst_n, clkgate_en_n, ram_ret_n, pwr_on, busy, timeout};
  endfunction

  // ctl = {switch_n, iso_n, rst_n, clkgate_en_n, ram_retentive_n}; flg = {pwr_on, busy, timeout}
  task automatic push(input logic [3:0] st, input logic [4:0] ctl, input logic [2:0] flg, input int gap);
    exp_t e;
    e.vec = {st, ctl, flg};
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input logic [3:0] st, input int max_cyc, input string nm);
    int n;
    n = 0;
    while (state !== st && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== st) begin
      failures++;
      $display("FAIL wait_%s state=%0d required=%0d within %0d cycles", nm, state, st, max_cyc);
    end
  endtask

  task automatic check_reset(input string nm);
    logic [11:0] got;
    got = outs();
    checks++;
    if (got !== {4'd0, 5'b10001, 3'b000}) begin
      failures++;
      $display("FAIL %s got st=%0d ctl=%b flg=%b required st=0 ctl=10001 flg=000",
               nm, got[11:8], got[7:3], got[2:0]);
    end
  endtask

  // Monitor: pop and compare on every change of the observed output tuple.
  initial begin : monitor
    logic [11:0] prev;
    logic [11:0] cur;
    int last;
    bit first;
    exp_t e;
    first = 1'b1;
    last = 0;
    prev = 12'h000;
    forever begin
      @(negedge clk);
      cyc++;
      cur = outs();
      if (first || cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d got st=%0d ctl=%b flg=%b",
                   cyc, cur[11:8], cur[7:3], cur[2:0]);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.vec || (e.gap >= 0 && (cyc - last) != e.gap)) begin
            failures++;
            $display("FAIL event cyc=%0d got st=%0d ctl=%b flg=%b gap=%0d required st=%0d ctl=%b flg=%b gap=%0d",
                     cyc, cur[11:8], cur[7:3], cur[2:0], cyc - last,
                     e.vec[11:8], e.vec[7:3], e.vec[2:0], e.gap);
          end
        end
        prev = cur;
        last = cyc;
        first = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // 1: reset and idle in OFF
    push(OFF, 5'b10001, 3'b000, -1);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_reset("reset_idle");

    // 2: power-on order and dwell
    push(ON_SWITCH, 5'b00001, 3'b010, -1);
    push(ON_RST,    5'b00101, 3'b010, 17);
    push(ON_ISO,    5'b01101, 3'b010, 4);
    push(ON_CLK,    5'b01111, 3'b010, 4);
    push(ON,        5'b01111, 3'b100, 4);
    pwr_on_req = 1'b1;
    wait_state(ON, 32, "power_on");

    // 3: power-off order
    push(OFF_CLK,    5'b01101, 3'b010, 1);
    push(OFF_ISO,    5'b00101, 3'b010, 4);
    push(OFF_RST,    5'b00001, 3'b010, 4);
    push(OFF_SWITCH, 5'b10001, 3'b010, 4);
    push(OFF,        5'b10001, 3'b000, 17);
    pwr_on_req = 1'b0;
    wait_state(OFF, 60, "power_off");

    // 4: stuck ack -> timeout, then release and clear
    push(ON_SWITCH, 5'b00001, 3'b010, 1);
    push(ON_SWITCH, 5'b00001, 3'b011, 64);
    push(ON_RST,    5'b00101, 3'b011, -1);
    push(ON_ISO,    5'b01101, 3'b011, 4);
    push(ON_CLK,    5'b01111, 3'b011, 4);
    push(ON,        5'b01111, 3'b101, 4);
    push(ON,        5'b01111, 3'b100, 1);
    ack_stuck = 1'b1;
    pwr_on_req = 1'b1;
    for (int n = 0; n < 80 && timeout !== 1'b1; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    ack_stuck = 1'b0;
    wait_state(ON, 40, "after_timeout");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // 5a: power down, then reverse the request mid power-up
    push(OFF_CLK,    5'b01101, 3'b010, 1);
    push(OFF_ISO,    5'b00101, 3'b010, 4);
    push(OFF_RST,    5'b00001, 3'b010, 4);
    push(OFF_SWITCH, 5'b10001, 3'b010, 4);
    push(OFF,        5'b10001, 3'b000, 17);
    pwr_on_req = 1'b0;
    wait_state(OFF, 60, "off_before_toggle");
    push(ON_SWITCH,  5'b00001, 3'b010, 1);
    push(ON_RST,     5'b00101, 3'b010, 17);
    push(ON_ISO,     5'b01101, 3'b010, 4);
    push(ON_CLK,     5'b01111, 3'b010, 4);
    push(ON,         5'b01111, 3'b100, 4);
    push(OFF_CLK,    5'b01101, 3'b010, 1);
    push(OFF_ISO,    5'b00101, 3'b010, 4);
    push(OFF_RST,    5'b00001, 3'b010, 4);
    push(OFF_SWITCH, 5'b10001, 3'b010, 4);
    push(OFF,        5'b10001, 3'b000, 17);
    pwr_on_req = 1'b1;
    wait_state(ON_ISO, 40, "on_iso");
    pwr_on_req = 1'b0;
    wait_state(OFF, 60, "off_after_toggle");

    // 5b: retention only in ON, released on leaving ON
    push(ON_SWITCH,  5'b00001, 3'b010, 1);
    push(ON_RST,     5'b00101, 3'b010, 17);
    push(ON_ISO,     5'b01101, 3'b010, 4);
    push(ON_CLK,     5'b01111, 3'b010, 4);
    push(ON,         5'b01110, 3'b100, 4);
    push(ON,         5'b01111, 3'b100, 1);
    push(ON,         5'b01110, 3'b100, 1);
    push(OFF_CLK,    5'b01101, 3'b010, 1);
    push(OFF_ISO,    5'b00101, 3'b010, 4);
    push(OFF_RST,    5'b00001, 3'b010, 4);
    push(OFF_SWITCH, 5'b10001, 3'b010, 4);
    push(OFF,        5'b10001, 3'b000, 17);
    ret_req = 1'b1;
    pwr_on_req = 1'b1;
    wait_state(ON, 40, "on_ret");
    ret_req = 1'b0;
    @(negedge clk);
    ret_req = 1'b1;
    @(negedge clk);
    pwr_on_req = 1'b0;
    wait_state(OFF, 60, "off_ret");
    ret_req = 1'b0;

    // 6a: reset during ON_RST
    push(ON_SWITCH, 5'b00001, 3'b010, 1);
    push(ON_RST,    5'b00101, 3'b010, 17);
    push(OFF,       5'b10001, 3'b000, 1);
    pwr_on_req = 1'b1;
    wait_state(ON_RST, 40, "on_rst");
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset_on_rst");
    pwr_on_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 6b: full restart, then reset during OFF_SWITCH
    push(ON_SWITCH,  5'b00001, 3'b010, -1);
    push(ON_RST,     5'b00101, 3'b010, 17);
    push(ON_ISO,     5'b01101, 3'b010, 4);
    push(ON_CLK,     5'b01111, 3'b010, 4);
    push(ON,         5'b01111, 3'b100, 4);
    push(OFF_CLK,    5'b01101, 3'b010, 1);
    push(OFF_ISO,    5'b00101, 3'b010, 4);
    push(OFF_RST,    5'b00001, 3'b010, 4);
    push(OFF_SWITCH, 5'b10001, 3'b010, 4);
    push(OFF,        5'b10001, 3'b000, 1);
    pwr_on_req = 1'b1;
    wait_state(ON, 40, "restart_on");
    pwr_on_req = 1'b0;
    wait_state(OFF_SWITCH, 20, "off_switch");
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset_off_switch");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
